// File: rtl/cycle_counter.sv
// Run-length counter: one start launches limit+1 enabled counts (up or down),
// then a single-cycle done pulse. Outputs decode registered state only.
module cycle_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  input  logic             down,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic [WIDTH-1:0] limit_reg, limit_next;
  logic             down_reg, down_next;
  logic [WIDTH-1:0] term;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg <= IDLE;
      out_reg   <= '0;
      limit_reg <= '0;
      down_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
      limit_reg <= limit_next;
      down_reg  <= down_next;
    end
  end

  // The terminal value is the last count of the run; reaching it with en
  // high ends the run, so the counter can never step past it or wrap.
  assign term = down_reg ? '0 : limit_reg;

  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
    limit_next = limit_reg;
    down_next  = down_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          limit_next = limit;
          down_next  = down;
          out_next   = down ? limit : '0;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (en) begin
          if (out_reg == term) begin
            state_next = DONE;
          end else if (down_reg) begin
            out_next = out_reg - WIDTH'(1);
          end else begin
            out_next = out_reg + WIDTH'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign out  = out_reg;
  assign busy = (state_reg == RUN);
  assign tc   = (state_reg == RUN) && (out_reg == term);
  assign done = (state_reg == DONE);

endmodule

// File: tb/tb_cycle_counter.sv
// Directed bench for cycle_counter: stimulus pushes the expected post-edge
// outputs into a queue; a monitor pops and compares one entry per clock edge.
module tb_cycle_counter;

  localparam int WIDTH = 6;

  logic             clk = 1'b0;
  logic             clr, start, en, down;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] out;
  logic             busy, tc, done;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             tc;
    logic             done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   step_id = 0;
  bit   stim_done = 1'b0;

  cycle_counter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .clr(clr), .start(start), .en(en), .limit(limit),
    .down(down), .out(out), .busy(busy), .tc(tc), .done(done)
  );

  always #5 clk = ~clk;

  // Apply inputs for one edge and record the outputs required after it.
  task automatic step(input logic c, input logic s, input logic e,
                      input logic [WIDTH-1:0] lim, input logic d,
                      input logic [WIDTH-1:0] eo, input logic eb,
                      input logic et, input logic ed);
    exp_t x;
    @(negedge clk);
    clr = c; start = s; en = e; limit = lim; down = d;
    x.id = step_id; x.out = eo; x.busy = eb; x.tc = et; x.done = ed;
    exp_q.push_back(x);
    step_id++;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checks++;
        if (out === x.out && busy === x.busy && tc === x.tc && done === x.done) begin
          passed++;
          $display("step %0d: out=%0d busy=%b tc=%b done=%b ok",
                   x.id, out, busy, tc, done);
        end else begin
          $display("FAIL step %0d: got out=%0d busy=%b tc=%b done=%b, want out=%0d busy=%b tc=%b done=%b",
                   x.id, out, busy, tc, done, x.out, x.busy, x.tc, x.done);
        end
      end
    end
  end

  initial begin : stimulus
    clr = 1'b1; start = 1'b1; en = 1'b1; limit = '0; down = 1'b0;

    // Reset with start/en high: clr wins.
    step(1, 1, 1, 6'd5, 0, 6'd0, 0, 0, 0);
    step(1, 1, 1, 6'd5, 0, 6'd0, 0, 0, 0);
    step(0, 0, 1, 6'd0, 0, 6'd0, 0, 0, 0);

    // limit=5 up, en held high.
    step(0, 1, 1, 6'd5, 0, 6'd0, 1, 0, 0);
    step(0, 0, 1, 6'd5, 0, 6'd1, 1, 0, 0);
    step(0, 0, 1, 6'd5, 0, 6'd2, 1, 0, 0);
    step(0, 0, 1, 6'd5, 0, 6'd3, 1, 0, 0);
    step(0, 0, 1, 6'd5, 0, 6'd4, 1, 0, 0);
    step(0, 0, 1, 6'd5, 0, 6'd5, 1, 1, 0);
    step(0, 0, 1, 6'd5, 0, 6'd5, 0, 0, 1);
    step(0, 0, 1, 6'd5, 0, 6'd5, 0, 0, 0);
    step(0, 0, 1, 6'd9, 1, 6'd5, 0, 0, 0);

    // limit=3 down, en toggling; mid-run start/limit/down changes ignored.
    step(0, 1, 1, 6'd3, 1, 6'd3, 1, 0, 0);
    step(0, 0, 0, 6'd3, 1, 6'd3, 1, 0, 0);
    step(0, 1, 1, 6'd9, 0, 6'd2, 1, 0, 0);
    step(0, 0, 0, 6'd9, 0, 6'd2, 1, 0, 0);
    step(0, 0, 1, 6'd3, 1, 6'd1, 1, 0, 0);
    step(0, 0, 0, 6'd3, 1, 6'd1, 1, 0, 0);
    step(0, 0, 1, 6'd3, 1, 6'd0, 1, 1, 0);
    step(0, 0, 0, 6'd3, 1, 6'd0, 1, 1, 0);
    step(0, 0, 1, 6'd3, 1, 6'd0, 0, 0, 1);
    step(0, 0, 1, 6'd3, 1, 6'd0, 0, 0, 0);

    // limit=0: single RUN cycle with tc immediately.
    step(0, 1, 1, 6'd0, 0, 6'd0, 1, 1, 0);
    step(0, 0, 1, 6'd0, 0, 6'd0, 0, 0, 1);
    step(0, 0, 1, 6'd0, 0, 6'd0, 0, 0, 0);

    // limit=63 up: full range, no wrap.
    step(0, 1, 1, 6'd63, 0, 6'd0, 1, 0, 0);
    for (int i = 1; i <= 63; i++)
      step(0, 0, 1, 6'd63, 0, 6'(i), 1, (i == 63), 0);
    step(0, 0, 1, 6'd63, 0, 6'd63, 0, 0, 1);
    step(0, 0, 1, 6'd63, 0, 6'd63, 0, 0, 0);

    // limit=63 down: reaches 0 and stops.
    step(0, 1, 1, 6'd63, 1, 6'd63, 1, 0, 0);
    for (int i = 62; i >= 0; i--)
      step(0, 0, 1, 6'd63, 1, 6'(i), 1, (i == 0), 0);
    step(0, 0, 1, 6'd63, 1, 6'd0, 0, 0, 1);
    step(0, 0, 1, 6'd63, 1, 6'd0, 0, 0, 0);

    // start held high, limit=2: runs chain through DONE with no idle gap.
    step(0, 1, 1, 6'd2, 0, 6'd0, 1, 0, 0);
    step(0, 1, 1, 6'd7, 0, 6'd1, 1, 0, 0);
    step(0, 1, 1, 6'd7, 0, 6'd2, 1, 1, 0);
    step(0, 1, 1, 6'd7, 0, 6'd2, 0, 0, 1);
    step(0, 1, 1, 6'd2, 0, 6'd0, 1, 0, 0);
    step(0, 1, 1, 6'd2, 0, 6'd1, 1, 0, 0);
    step(0, 1, 1, 6'd2, 0, 6'd2, 1, 1, 0);
    step(0, 0, 1, 6'd2, 0, 6'd2, 0, 0, 1);
    step(0, 0, 1, 6'd2, 0, 6'd2, 0, 0, 0);

    // clr at out=4 of a limit=10 run: abort, no done ever.
    step(0, 1, 1, 6'd10, 0, 6'd0, 1, 0, 0);
    step(0, 0, 1, 6'd10, 0, 6'd1, 1, 0, 0);
    step(0, 0, 1, 6'd10, 0, 6'd2, 1, 0, 0);
    step(0, 0, 1, 6'd10, 0, 6'd3, 1, 0, 0);
    step(0, 0, 1, 6'd10, 0, 6'd4, 1, 0, 0);
    step(1, 0, 1, 6'd10, 0, 6'd0, 0, 0, 0);
    step(0, 0, 1, 6'd10, 0, 6'd0, 0, 0, 0);
    step(0, 0, 1, 6'd10, 0, 6'd0, 0, 0, 0);
    step(0, 0, 1, 6'd10, 0, 6'd0, 0, 0, 0);

    stim_done = 1'b1;
  end

  initial begin : finisher
    int budget;
    wait (stim_done);
    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1, "timeout");
  end

endmodule
